// File: rtl/grp_fade_ctrl.sv
// grp_fade_ctrl
//   Ramps the group PWM duty (grp_pwm_reg) from its current value toward a
//   requested target, one STEP_SIZE step every R+1 clocks, so host writes
//   fade rather than jump. Blink mode applies the target immediately.
//   Runs entirely in the 6.25 kHz domain.
//
// Ports
//   clk_6p25K    in   6.25 kHz clock, all state changes on rising edge
//   reset_n      in   async active-low reset
//   sleep        in   freeze everything; start/abort ignored
//   start        in   begin or retarget a fade (one cycle)
//   abort        in   stop a running fade, hold duty (wins over start)
//   target_duty  in   [7:0] final duty, sampled on accepted start
//   fade_rate    in   [7:0] clocks per step minus one, sampled on accepted start
//   dim_blink    in   0 = ramp, 1 = apply immediately
//   grp_pwm_reg  out  [7:0] duty driven to group_pwm
//   busy         out  high while ramping
//   done         out  one-cycle pulse when the target is reached
module grp_fade_ctrl #(
  parameter int         STEP_SIZE  = 1,
  parameter logic [7:0] RESET_DUTY = 8'h00
) (
  input  logic       clk_6p25K,
  input  logic       reset_n,
  input  logic       sleep,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] target_duty,
  input  logic [7:0] fade_rate,
  input  logic       dim_blink,
  output logic [7:0] grp_pwm_reg,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {S_IDLE, S_RAMP, S_DONE} state_t;

  state_t     r_state;
  logic [7:0] r_duty;
  logic [7:0] r_tgt;
  logic [7:0] r_rate;
  logic [7:0] r_cnt;
  logic       r_busy;
  logic       r_done;

  // 9-bit step arithmetic so a step can never wrap past 00/FF; any step
  // that would overshoot the target lands exactly on it.
  logic [8:0] w_step, w_cur, w_tgt, w_up, w_dn, w_dn_lim;
  logic [7:0] w_next;

  assign w_step   = 9'(STEP_SIZE);
  assign w_cur    = {1'b0, r_duty};
  assign w_tgt    = {1'b0, r_tgt};
  assign w_up     = w_cur + w_step;
  assign w_dn     = w_cur - w_step;
  assign w_dn_lim = w_tgt + w_step;

  always_comb begin
    w_next = r_tgt;
    if (r_tgt > r_duty) begin
      if (w_up < w_tgt) w_next = w_up[7:0];
    end else begin
      if (w_cur > w_dn_lim) w_next = w_dn[7:0];
    end
  end

  // start is accepted in IDLE or RAMP; in DONE it is dropped.
  logic w_accept;
  assign w_accept = start && !abort && (r_state != S_DONE);

  always_ff @(posedge clk_6p25K or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_duty  <= RESET_DUTY;
      r_tgt   <= RESET_DUTY;
      r_rate  <= 8'h00;
      r_cnt   <= 8'h00;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (!sleep) begin
      r_done <= 1'b0;
      if (abort && r_state == S_RAMP) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else if (w_accept) begin
        r_tgt  <= target_duty;
        r_rate <= fade_rate;
        if (dim_blink || target_duty == r_duty) begin
          r_duty  <= target_duty;
          r_state <= S_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end else begin
          // accepting edge never moves the duty, even on retarget
          r_cnt   <= fade_rate;
          r_state <= S_RAMP;
          r_busy  <= 1'b1;
        end
      end else begin
        case (r_state)
          S_RAMP: begin
            if (r_cnt != 8'h00) begin
              r_cnt <= r_cnt - 8'h01;
            end else begin
              r_duty <= w_next;
              r_cnt  <= r_rate;
              if (w_next == r_tgt) begin
                r_state <= S_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign grp_pwm_reg = r_duty;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_grp_fade_ctrl.sv
module tb_grp_fade_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sleep, abort, blink;
  logic       start1, start3;
  logic [7:0] target, rate;
  logic [7:0] duty1, duty3;
  logic       busy1, busy3, done1, done3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  grp_fade_ctrl #(.STEP_SIZE(1), .RESET_DUTY(8'h00)) u1 (
    .clk_6p25K(clk), .reset_n(rst_n), .sleep(sleep), .start(start1),
    .abort(abort), .target_duty(target), .fade_rate(rate),
    .dim_blink(blink), .grp_pwm_reg(duty1), .busy(busy1), .done(done1)
  );

  grp_fade_ctrl #(.STEP_SIZE(3), .RESET_DUTY(8'h00)) u3 (
    .clk_6p25K(clk), .reset_n(rst_n), .sleep(sleep), .start(start3),
    .abort(abort), .target_duty(target), .fade_rate(rate),
    .dim_blink(blink), .grp_pwm_reg(duty3), .busy(busy3), .done(done3)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // sample one time unit after the rising edge, drive inputs there too
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one-cycle start on u1 (s==1) or u3 (s==3)
  task automatic go(input int s, input logic [7:0] t, input logic [7:0] r, input logic b);
    target = t; rate = r; blink = b;
    if (s == 1) start1 = 1'b1; else start3 = 1'b1;
    tick();
    start1 = 1'b0; start3 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; sleep = 1'b0; abort = 1'b0; blink = 1'b0;
    start1 = 1'b0; start3 = 1'b0; target = 8'h00; rate = 8'h00;
    #12;
    chk("rst_duty", duty1, 8'h00);
    chk("rst_busy", {7'd0, busy1}, 8'h00);
    chk("rst_done", {7'd0, done1}, 8'h00);
    tick();
    rst_n = 1'b1;
    tick();

    // up-ramp 00 -> 04, R=2: steps at edges 3/6/9/12
    go(1, 8'h04, 8'h02, 1'b0);
    chk("up_e0_duty", duty1, 8'h00);
    chk("up_e0_busy", {7'd0, busy1}, 8'h01);
    for (int e = 1; e <= 12; e++) begin
      tick();
      chk($sformatf("up_e%0d_duty", e), duty1, 8'(e / 3));
      chk($sformatf("up_e%0d_busy", e), {7'd0, busy1}, (e < 12) ? 8'h01 : 8'h00);
      chk($sformatf("up_e%0d_done", e), {7'd0, done1}, (e == 12) ? 8'h01 : 8'h00);
    end
    tick();
    chk("up_e13_done", {7'd0, done1}, 8'h00);
    chk("up_e13_busy", {7'd0, busy1}, 8'h00);

    // down-ramp with saturation, STEP=3: 0A -> 07 04 01 00
    go(3, 8'h0A, 8'h00, 1'b1);
    tick();
    chk("dn_pre_duty", duty3, 8'h0A);
    go(3, 8'h00, 8'h00, 1'b0);
    chk("dn_e0_duty", duty3, 8'h0A);
    chk("dn_e0_busy", {7'd0, busy3}, 8'h01);
    tick(); chk("dn_e1", duty3, 8'h07);
    tick(); chk("dn_e2", duty3, 8'h04);
    tick(); chk("dn_e3", duty3, 8'h01);
    chk("dn_e3_done", {7'd0, done3}, 8'h00);
    tick(); chk("dn_e4", duty3, 8'h00);
    chk("dn_e4_done", {7'd0, done3}, 8'h01);
    tick();
    chk("dn_e5_done", {7'd0, done3}, 8'h00);
    chk("dn_e5_duty", duty3, 8'h00);

    // blink bypass 10 -> C0
    go(1, 8'h10, 8'h00, 1'b1);
    tick();
    go(1, 8'hC0, 8'h05, 1'b1);
    chk("bl_duty", duty1, 8'hC0);
    chk("bl_busy", {7'd0, busy1}, 8'h00);
    chk("bl_done", {7'd0, done1}, 8'h01);
    tick();
    chk("bl_done2", {7'd0, done1}, 8'h00);
    chk("bl_busy2", {7'd0, busy1}, 8'h00);

    // retarget: 00 -> 80 R=1, at 05 retarget to 02 R=0
    go(1, 8'h00, 8'h00, 1'b1);
    tick();
    go(1, 8'h80, 8'h01, 1'b0);
    for (int e = 1; e <= 10; e++) tick();
    chk("rt_at5", duty1, 8'h05);
    go(1, 8'h02, 8'h00, 1'b0);
    chk("rt_acc_duty", duty1, 8'h05);
    chk("rt_acc_busy", {7'd0, busy1}, 8'h01);
    tick(); chk("rt_1", duty1, 8'h04);
    tick(); chk("rt_2", duty1, 8'h03);
    tick(); chk("rt_3", duty1, 8'h02);
    chk("rt_done", {7'd0, done1}, 8'h01);
    tick();
    chk("rt_done_end", {7'd0, done1}, 8'h00);

    // sleep shifts the schedule: 02 -> 06 R=1, step 03 at edge 2, 04 at edge 4+3
    go(1, 8'h06, 8'h01, 1'b0);
    tick();
    tick(); chk("sl_e2", duty1, 8'h03);
    sleep = 1'b1;
    for (int e = 0; e < 3; e++) begin
      tick();
      chk($sformatf("sl_hold%0d", e), duty1, 8'h03);
    end
    sleep = 1'b0;
    tick(); chk("sl_e6", duty1, 8'h03);
    tick(); chk("sl_e7", duty1, 8'h04);
    chk("sl_busy", {7'd0, busy1}, 8'h01);

    // start + abort together: abort wins, duty held, no done
    target = 8'h20; start1 = 1'b1; abort = 1'b1;
    tick();
    start1 = 1'b0; abort = 1'b0;
    chk("ab_duty", duty1, 8'h04);
    chk("ab_busy", {7'd0, busy1}, 8'h00);
    chk("ab_done", {7'd0, done1}, 8'h00);
    tick();
    chk("ab_done2", {7'd0, done1}, 8'h00);
    chk("ab_duty2", duty1, 8'h04);

    // async reset mid-ramp
    go(1, 8'h40, 8'h00, 1'b0);
    tick();
    tick();
    chk("rr_pre", duty1, 8'h06);
    #2 rst_n = 1'b0;
    #1;
    chk("rr_duty", duty1, 8'h00);
    chk("rr_busy", {7'd0, busy1}, 8'h00);
    chk("rr_done", {7'd0, done1}, 8'h00);
    tick();
    chk("rr_done2", {7'd0, done1}, 8'h00);
    rst_n = 1'b1;
    tick();
    chk("rr_idle_duty", duty1, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
